// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: word width,
// state encoding and the default reset fetch address.
package fetch_ctrl_pkg;

    localparam int WORD = 32;

    localparam logic [WORD-1:0] DEFAULT_RESET_PC = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one word request at a time, holds the
// returned instruction for the decoder and follows redirects from downstream.
//
// Handshakes:
//   memory side  : mem_req/mem_addr stay stable from request until the cycle
//                  mem_ack=1; mem_rdata is sampled in that cycle.
//   decoder side : inst/inst_pc are stable while inst_valid=1; a handoff
//                  happens on a rising edge where inst_valid=1 and inst_ready=1.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int               WIDTH    = WORD,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             inst_valid,
    output logic [WIDTH-1:0] inst,
    output logic [WIDTH-1:0] inst_pc,
    input  logic             inst_ready,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0] fetch_count,
    output fetch_state_e     state_dbg
);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic             kill_q, kill_d;
    logic [WIDTH-1:0] inst_q, inst_d;
    logic [WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic [WIDTH-1:0] count_q, count_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC;
            kill_q    <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            kill_q    <= kill_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            count_q   <= count_d;
        end
    end

    // addr_q is the address of the outstanding request; pc_q may already
    // point elsewhere after a redirect while that request is still in flight.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        kill_d    = kill_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        count_d   = count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    pc_d   = redirect_pc;
                    addr_d = redirect_pc;
                end else if (run) begin
                    state_d = ST_REQ;
                    addr_d  = pc_q;
                end
            end

            ST_REQ: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (mem_ack) begin
                    if (kill_q || redirect) begin
                        kill_d  = 1'b0;
                        addr_d  = pc_d;
                        state_d = run ? ST_REQ : ST_IDLE;
                    end else begin
                        inst_d    = mem_rdata;
                        inst_pc_d = addr_q;
                        state_d   = ST_HOLD;
                    end
                end else if (redirect) begin
                    kill_d = 1'b1;
                end
            end

            ST_HOLD: begin
                if (inst_ready || redirect) begin
                    if (inst_ready) begin
                        count_d = count_q + WIDTH'(1);
                    end
                    // A redirect overrides the sequential successor even when
                    // the held instruction is accepted in the same cycle.
                    pc_d    = redirect ? redirect_pc : pc_q + WIDTH'(1);
                    addr_d  = pc_d;
                    state_d = run ? ST_REQ : ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                kill_d  = 1'b0;
            end
        endcase
    end

    assign mem_req     = (state_q == ST_REQ);
    assign mem_addr    = addr_q;
    assign inst_valid  = (state_q == ST_HOLD);
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign fetch_count = count_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a memory responder with programmable ack
// delay, expected request/handoff queues, and a negedge monitor that checks them.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         run = 1'b0;
    logic         mem_req;
    logic [W-1:0] mem_addr;
    logic         mem_ack = 1'b0;
    logic [W-1:0] mem_rdata = '0;
    logic         inst_valid;
    logic [W-1:0] inst;
    logic [W-1:0] inst_pc;
    logic         inst_ready = 1'b0;
    logic         redirect = 1'b0;
    logic [W-1:0] redirect_pc = '0;
    logic [W-1:0] fetch_count;
    fetch_state_e state_dbg;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] exp_req_q[$];
    logic [W-1:0] exp_q[$];

    logic ack_en = 1'b1;
    int   ack_delay = 2;
    int   ack_cnt = 0;

    fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_count (fetch_count),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] data_of(input logic [W-1:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- memory responder ----------------
    always @(posedge clk) begin
        #1;
        if (ack_en) begin
            mem_ack   = 1'b0;
            mem_rdata = 32'hDEAD_BEEF;
            if (rst && mem_req) begin
                ack_cnt++;
                if (ack_cnt > ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = data_of(mem_addr);
                    ack_cnt   = 0;
                end
            end else begin
                ack_cnt = 0;
            end
        end else begin
            ack_cnt = 0;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst) begin
            if (mem_req && inst_valid) begin
                tests++;
                fails++;
                $display("FAIL req_valid_overlap: mem_req=1 inst_valid=1 required not both");
            end
            if (mem_req && mem_ack) begin
                if (exp_req_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL req_unexpected: acked addr 0x%08h, none expected", mem_addr);
                end else begin
                    e = exp_req_q.pop_front();
                    check("req_addr", mem_addr, e);
                end
            end
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL handoff_unexpected: inst_pc 0x%08h, none expected", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("handoff_pc", inst_pc, e);
                    check("handoff_inst", inst, data_of(e));
                end
            end
        end
    end

    // ---------------- bounded waits ----------------
    task automatic wait_addr(input logic [W-1:0] a, input string name);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!(mem_req && mem_addr == a) && i < 100);
        check({name, "_req_seen"}, {31'b0, mem_req && mem_addr == a}, 32'd1);
    endtask

    task automatic wait_ack(input string name);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!(mem_req && mem_ack) && i < 100);
        check({name, "_ack_seen"}, {31'b0, mem_req && mem_ack}, 32'd1);
    endtask

    task automatic wait_valid(input string name);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!inst_valid && i < 100);
        check({name, "_valid_seen"}, {31'b0, inst_valid}, 32'd1);
    endtask

    task automatic wait_idle(input logic [W-1:0] cnt, input string name);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!(state_dbg == ST_IDLE && fetch_count == cnt) && i < 200);
        check({name, "_count"}, fetch_count, cnt);
        check({name, "_idle"}, {31'b0, state_dbg == ST_IDLE}, 32'd1);
        check({name, "_no_req"}, {31'b0, mem_req}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset values
        #2;
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_fetch_count", fetch_count, 32'd0);

        // Sequential fetch 0..3, ack two cycles after each request
        for (int a = 0; a < 4; a++) begin
            exp_req_q.push_back(W'(a));
            exp_q.push_back(W'(a));
        end
        run = 1'b1;
        inst_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        wait_ack("seq_first");
        @(negedge clk);
        check("latency_valid", {31'b0, inst_valid}, 32'd1);
        check("latency_pc", inst_pc, 32'h0);
        begin
            int i = 0;
            while (fetch_count != 32'd3 && i < 100) begin
                @(negedge clk);
                i++;
            end
        end
        tick();
        run = 1'b0;
        wait_idle(32'd4, "seq");
        repeat (3) begin
            @(negedge clk);
            check("idle_no_req", {31'b0, mem_req}, 32'd0);
        end

        // Decoder stall for 5 cycles in HOLD at address 4
        exp_req_q.push_back(32'h4);
        exp_q.push_back(32'h4);
        tick();
        inst_ready = 1'b0;
        run = 1'b1;
        wait_valid("stall");
        tick();
        run = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_inst", inst, data_of(32'h4));
            check("stall_pc", inst_pc, 32'h4);
            check("stall_no_req", {31'b0, mem_req}, 32'd0);
        end
        tick();
        inst_ready = 1'b1;
        wait_idle(32'd5, "stall");

        // Reset asserted while a request at 5 is outstanding
        ack_en = 1'b0;
        tick();
        run = 1'b1;
        wait_addr(32'h5, "pre_rst");
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("mid_rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("mid_rst_mem_addr", mem_addr, 32'h0);
        check("mid_rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("mid_rst_inst", inst, 32'h0);
        check("mid_rst_inst_pc", inst_pc, 32'h0);
        check("mid_rst_count", fetch_count, 32'h0);
        run = 1'b0;
        @(negedge clk);
        tick();
        rst = 1'b1;
        // A stray ack while idle must be ignored
        tick();
        mem_ack = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        repeat (3) begin
            @(negedge clk);
            check("stray_ack_valid", {31'b0, inst_valid}, 32'd0);
            check("stray_ack_idle", {31'b0, state_dbg == ST_IDLE}, 32'd1);
        end
        tick();
        mem_ack = 1'b0;
        @(negedge clk);
        ack_en = 1'b1;

        // Redirect to 0x100 while waiting on the ack for address 2
        exp_req_q.push_back(32'h0);
        exp_req_q.push_back(32'h1);
        exp_req_q.push_back(32'h2);
        exp_req_q.push_back(32'h100);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h100);
        tick();
        run = 1'b1;
        wait_addr(32'h2, "kill");
        ack_en = 1'b0;
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("kill_hold_addr", mem_addr, 32'h2);
            check("kill_hold_req", {31'b0, mem_req}, 32'd1);
        end
        ack_en = 1'b1;
        wait_ack("kill");
        @(negedge clk);
        check("kill_next_addr", mem_addr, 32'h100);
        check("kill_no_valid", {31'b0, inst_valid}, 32'd0);
        tick();
        run = 1'b0;
        wait_idle(32'd3, "kill");

        // Redirect to 0x40 in HOLD, first with inst_ready=0, then with inst_ready=1
        exp_req_q.push_back(32'h101);
        exp_req_q.push_back(32'h40);
        tick();
        inst_ready = 1'b0;
        run = 1'b1;
        wait_valid("drop");
        check("drop_held_pc", inst_pc, 32'h101);
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        @(negedge clk);
        check("drop_valid_low", {31'b0, inst_valid}, 32'd0);
        check("drop_count", fetch_count, 32'd3);
        check("drop_next_addr", mem_addr, 32'h40);
        wait_valid("redir_ready");
        exp_q.push_back(32'h40);
        exp_req_q.push_back(32'h40);
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h40;
        inst_ready = 1'b1;
        tick();
        redirect = 1'b0;
        run = 1'b0;
        exp_q.push_back(32'h40);
        @(negedge clk);
        check("redir_ready_count", fetch_count, 32'd4);
        check("redir_ready_addr", mem_addr, 32'h40);
        wait_idle(32'd5, "redir_ready");

        // Redirect in the same cycle as mem_ack
        ack_en = 1'b0;
        tick();
        run = 1'b1;
        wait_addr(32'h41, "same_cycle");
        exp_req_q.push_back(32'h41);
        exp_req_q.push_back(32'h200);
        exp_q.push_back(32'h200);
        tick();
        mem_ack = 1'b1;
        mem_rdata = data_of(32'h41);
        redirect = 1'b1;
        redirect_pc = 32'h200;
        tick();
        mem_ack = 1'b0;
        redirect = 1'b0;
        @(negedge clk);
        check("same_cycle_addr", mem_addr, 32'h200);
        check("same_cycle_no_valid", {31'b0, inst_valid}, 32'd0);
        check("same_cycle_count", fetch_count, 32'd5);
        ack_en = 1'b1;
        tick();
        run = 1'b0;
        wait_idle(32'd6, "same_cycle");

        // Redirect in IDLE to all-ones, then wrap to 0 at peak throughput
        tick();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        @(negedge clk);
        check("idle_redir_state", {31'b0, state_dbg == ST_IDLE}, 32'd1);
        ack_delay = 0;
        exp_req_q.push_back(32'hFFFF_FFFF);
        exp_req_q.push_back(32'h0);
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'h0);
        tick();
        run = 1'b1;
        wait_valid("wrap");
        check("wrap_top_pc", inst_pc, 32'hFFFF_FFFF);
        @(negedge clk);
        check("wrap_req", {31'b0, mem_req}, 32'd1);
        check("wrap_addr", mem_addr, 32'h0);
        tick();
        run = 1'b0;
        @(negedge clk);
        check("wrap_valid", {31'b0, inst_valid}, 32'd1);
        check("wrap_pc", inst_pc, 32'h0);
        wait_idle(32'd8, "wrap");

        check("req_queue_empty", W'(exp_req_q.size()), 32'd0);
        check("inst_queue_empty", W'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
